// File: rtl/traffic_pkg.sv
// Shared types and default timing constants for the traffic phase controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_ALLRED = 2'd2
  } state_t;

  localparam int unsigned DEF_NUM_PHASES   = 4;
  localparam int unsigned DEF_CLK_DIV      = 4;
  localparam int unsigned DEF_GREEN_TICKS  = 5;
  localparam int unsigned DEF_YELLOW_TICKS = 2;
  localparam int unsigned DEF_ALLRED_TICKS = 1;
  localparam int unsigned DEF_CNT_W        = 8;

endpackage

// File: rtl/traffic_phase_ctrl_tick_gen.sv
// Timing-tick prescaler: counts 0..CLK_DIV-1 and flags the terminal count.
module tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] cnt;
  logic [PRE_W-1:0] cnt_d;

  // Next prescaler value with wrap at the terminal count.
  always_comb begin
    cnt_d = cnt + PRE_W'(1);
    if (cnt == LAST) cnt_d = '0;
  end

  // Counter and registered tick; tick tracks cnt == LAST cycle for cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= (CLK_DIV == 1);
    end else begin
      cnt  <= cnt_d;
      tick <= (cnt_d == LAST);
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Traffic phase controller: green/yellow/all-red sequencing over NUM_PHASES
// approaches with sticky per-approach demand tracking.
// Optional demand-actuated skipping/resting: define TRAFFIC_DEMAND_SKIP_EN.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_PHASES   = DEF_NUM_PHASES,
  parameter int unsigned CLK_DIV      = DEF_CLK_DIV,
  parameter int unsigned GREEN_TICKS  = DEF_GREEN_TICKS,
  parameter int unsigned YELLOW_TICKS = DEF_YELLOW_TICKS,
  parameter int unsigned ALLRED_TICKS = DEF_ALLRED_TICKS,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PHASES-1:0]         request,
  output logic [NUM_PHASES-1:0]         green,
  output logic [NUM_PHASES-1:0]         yellow,
  output logic [NUM_PHASES-1:0]         red,
  output logic [$clog2(NUM_PHASES)-1:0] phase_idx,
  output logic [CNT_W-1:0]              remaining,
  output logic                          tick
);

  localparam int unsigned NP = NUM_PHASES;
  localparam int unsigned PW = $clog2(NUM_PHASES);

  state_t          state;
  state_t          state_d;
  logic [PW-1:0]   phase_d;
  logic [PW-1:0]   next_phase;
  logic [CNT_W-1:0] timer_d;
  logic [NP-1:0]   demand;
  logic [NP-1:0]   demand_d;
  logic [NP-1:0]   nxt_mask;
  logic [NP-1:0]   green_d;
  logic [NP-1:0]   yellow_d;

  tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

`ifdef TRAFFIC_DEMAND_SKIP_EN
  logic [NP-1:0] cur_mask;
  logic          other_demand;

  // Demand from any approach other than the one being served.
  always_comb begin
    cur_mask     = NP'(1) << phase_idx;
    other_demand = |(demand & ~cur_mask);
  end

  // Nearest following phase with demand; plain successor when none pending.
  always_comb begin
    next_phase = (phase_idx == PW'(NP - 1)) ? '0 : phase_idx + PW'(1);
    for (int unsigned k = NP; k >= 1; k--) begin
      if (demand[PW'((32'(phase_idx) + k) % NP)]) begin
        next_phase = PW'((32'(phase_idx) + k) % NP);
      end
    end
  end
`else
  logic unused_demand;

  // Demand is tracked but sequencing is fixed round-robin.
  always_comb begin
    unused_demand = ^demand;
    next_phase    = (phase_idx == PW'(NP - 1)) ? '0 : phase_idx + PW'(1);
  end
`endif

  // State register: FSM state, served phase and phase timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_ALLRED;
      phase_idx <= PW'(NP - 1);
      remaining <= CNT_W'(ALLRED_TICKS - 1);
    end else begin
      state     <= state_d;
      phase_idx <= phase_d;
      remaining <= timer_d;
    end
  end

  // Next state: timer counts down on tick, state changes only at tick with timer 0.
  always_comb begin
    state_d = state;
    phase_d = phase_idx;
    timer_d = remaining;
    if (tick) begin
      if (remaining != '0) begin
        timer_d = remaining - CNT_W'(1);
      end else begin
        case (state)
          S_GREEN: begin
`ifdef TRAFFIC_DEMAND_SKIP_EN
            if (other_demand) begin
              state_d = S_YELLOW;
              timer_d = CNT_W'(YELLOW_TICKS - 1);
            end else begin
              timer_d = CNT_W'(GREEN_TICKS - 1);
            end
`else
            state_d = S_YELLOW;
            timer_d = CNT_W'(YELLOW_TICKS - 1);
`endif
          end
          S_YELLOW: begin
            state_d = S_ALLRED;
            timer_d = CNT_W'(ALLRED_TICKS - 1);
          end
          S_ALLRED: begin
            state_d = S_GREEN;
            phase_d = next_phase;
            timer_d = CNT_W'(GREEN_TICKS - 1);
          end
          default: begin
            state_d = S_ALLRED;
            timer_d = CNT_W'(ALLRED_TICKS - 1);
          end
        endcase
      end
    end
  end

  // Output decode of the upcoming state so lamps register alongside it.
  always_comb begin
    nxt_mask = NP'(1) << phase_d;
    green_d  = '0;
    yellow_d = '0;
    case (state_d)
      S_GREEN:  green_d  = nxt_mask;
      S_YELLOW: yellow_d = nxt_mask;
      default:  ;
    endcase
  end

  // Sticky demand; the phase in (or entering) green has its bit held clear.
  always_comb begin
    demand_d = demand | request;
    if (state_d == S_GREEN) demand_d = demand_d & ~nxt_mask;
  end

  // Lamp and demand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      green  <= '0;
      yellow <= '0;
      red    <= '1;
      demand <= '0;
    end else begin
      green  <= green_d;
      yellow <= yellow_d;
      red    <= ~(green_d | yellow_d);
      demand <= demand_d;
    end
  end

endmodule

// File: doc/traffic_phase_ctrl.md
TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 SHALL have parameter NUM_PHASES, default 4; number of signalled approaches (legal range 2..8).
REQ-002 SHALL have parameter CLK_DIV, default 4; clk cycles per timing tick (legal range >=1).
REQ-003 SHALL have parameters GREEN_TICKS, YELLOW_TICKS and ALLRED_TICKS, defaults 5, 2 and 1; state durations in ticks (each 1..2^CNT_W-1).
REQ-004 SHALL have parameter CNT_W, default 8; phase timer width.
REQ-005 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit; reset, synchronous, active-high.
REQ-007 SHALL have port request, input, NUM_PHASES bits; per-approach demand, level or pulse.
REQ-008 SHALL have ports green, yellow and red, outputs, NUM_PHASES bits each; lamp drives, registered.
REQ-009 SHALL have port phase_idx, output, $clog2(NUM_PHASES) bits; approach currently served.
REQ-010 SHALL have port remaining, output, CNT_W bits; ticks left in current state minus one.
REQ-011 SHALL have port tick, output, 1 bit; one-clk pulse each CLK_DIV cycles.

Function
REQ-012 SHALL run a prescaler counting 0..CLK_DIV-1 and wrapping; tick is high while prescaler == CLK_DIV-1 (CLK_DIV=1: tick always high).
REQ-013 SHALL implement FSM states S_GREEN, S_YELLOW, S_ALLRED; timer loads duration-1 on state entry and decrements only on tick.
REQ-014 SHALL leave a state only on a clk edge where tick=1 and timer=0, so each state lasts exactly duration*CLK_DIV clk cycles.
REQ-015 SHALL sequence S_GREEN -> S_YELLOW -> S_ALLRED -> S_GREEN(next phase); phase_idx advances on the S_ALLRED->S_GREEN edge and wraps NUM_PHASES-1 -> 0.
REQ-016 SHALL drive green[phase_idx] in S_GREEN and yellow[phase_idx] in S_YELLOW; every other bit SHALL be red; S_ALLRED SHALL drive all red.
REQ-017 SHALL guarantee at most one bit of (green|yellow) is set in any cycle, and red = ~(green|yellow) always.
REQ-018 SHALL latch request[i] into sticky demand[i] every clk; demand[i] clears on entry to S_GREEN for phase i; a request for the served phase during its S_GREEN is discarded.
REQ-019 SHALL resolve simultaneous set and clear of demand[i] on the same edge as clear.

Reset
REQ-020 SHALL, on any clk edge with rst=1, from any state: state=S_ALLRED, timer=ALLRED_TICKS-1, prescaler=0, phase_idx=NUM_PHASES-1, demand=0.
REQ-021 SHALL hold outputs during and after reset at red=all ones, green=0, yellow=0, tick=0 until the prescaler wraps; the first served phase SHALL be phase 0.

Configuration
REQ-022 SHALL compile demand-actuated operation in only when macro TRAFFIC_DEMAND_SKIP_EN is defined.
REQ-023 SHALL, with TRAFFIC_DEMAND_SKIP_EN defined: on S_GREEN expiry, if no other phase has demand, rest in S_GREEN and reload the timer; otherwise enter S_YELLOW, and at S_ALLRED exit serve the nearest following phase (round-robin from phase_idx+1) with demand set.
REQ-024 SHALL, without TRAFFIC_DEMAND_SKIP_EN: run fixed round-robin through all phases regardless of demand; demand is still tracked but does not affect sequencing.

Structure
REQ-025 SHALL place the state enum (S_GREEN, S_YELLOW, S_ALLRED) and default duration constants in shared package traffic_pkg.
REQ-026 SHALL implement the prescaler as sub-module tick_gen (parameter CLK_DIV; ports clk, rst, tick).

Verification (NUM_PHASES=4, CLK_DIV=4, GREEN=5, YELLOW=2, ALLRED=1)
REQ-027 SHALL check that after rst deasserts, all red for 4 clk; green[0] rises after the 4th edge and lasts 20 clk; yellow[0] lasts 8 clk; all-red lasts 4 clk; then green[1].
REQ-028 SHALL check that, macro undefined and request=0, phases 0,1,2,3,0 are served; the period is 128 clk; one-hot (green|yellow) holds every cycle.
REQ-029 SHALL check that, macro defined with a single 1-clk pulse on request[2] during green[0], sequencing goes phase 0 -> yellow -> all-red -> green[2] (phases 1 and 3 skipped), then rests in green[2].
REQ-030 SHALL check that, macro defined with no demand, green[0] stays high indefinitely, with remaining reloading 4 -> 0 every 20 clk.
REQ-031 SHALL check that rst asserted for 1 clk mid-S_YELLOW of phase 2 gives all red on the next edge, demand cleared, and the restart serves phase 0.
REQ-032 SHALL check that, at CLK_DIV=1, tick stays high and green lasts exactly 5 clk.
